// File: rtl/window_accum_sequencer_pkg.sv
// Shared constants, FSM state type and sizing helper for the windowed
// scaled-sample accumulator and its companion blocks.
package window_accum_sequencer_pkg;

  localparam int unsigned WAS_X_W     = 4;
  localparam int unsigned WAS_SCALE   = 25;
  localparam int unsigned WAS_MAX_LEN = 16;
  localparam int unsigned WAS_LEN_W   = 5;
  localparam int unsigned WAS_SUM_W   = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Smallest accumulator width that holds max_len samples of (2^x_w-1)*scale.
  function automatic int unsigned sum_width_needed(input int unsigned max_len,
                                                   input int unsigned x_w,
                                                   input int unsigned scale);
    logic [63:0] max_sum;
    int unsigned bits;
    max_sum = 64'(max_len) * ((64'd1 << x_w) - 64'd1) * 64'(scale);
    bits = 0;
    while ((64'd1 << bits) <= max_sum) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/window_accum_sequencer_if.sv
// Sample input, result output and status signals of the window accumulator.
// master = sample source / result consumer side, slave = accumulator side.
interface window_accum_sequencer_if
  import window_accum_sequencer_pkg::*;
#(
  parameter int unsigned X_W   = WAS_X_W,
  parameter int unsigned LEN_W = WAS_LEN_W,
  parameter int unsigned SUM_W = WAS_SUM_W
);
  logic             in_valid;
  logic             in_ready;
  logic [X_W-1:0]   in_x;
  logic [LEN_W-1:0] win_len;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [LEN_W-1:0] out_count;
  logic             busy;

  modport master (
    output in_valid, in_x, win_len, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, busy
  );

  modport slave (
    input  in_valid, in_x, win_len, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, busy
  );
endinterface

// File: rtl/window_accum_sequencer_scale_mult.sv
// Constant-coefficient multiplier: in_x*SCALE as a 2^X_W-entry lookup table.
module window_accum_sequencer_scale_mult
  import window_accum_sequencer_pkg::*;
#(
  parameter int unsigned X_W   = WAS_X_W,
  parameter int unsigned SCALE = WAS_SCALE,
  parameter int unsigned SUM_W = WAS_SUM_W
) (
  input  logic [X_W-1:0]   in_x,
  output logic [SUM_W-1:0] prod
);
  logic [SUM_W-1:0] table_s [2**X_W];

  for (genvar i = 0; i < 2**X_W; i++) begin : g_table
    assign table_s[i] = SUM_W'(i * SCALE);
  end

  assign prod = table_s[in_x];
endmodule

// File: rtl/window_accum_sequencer.sv
// Window accumulator sequencer: sums in_x*SCALE over a programmable window,
// presents the result with a valid/ready handshake and holds it until taken.
module window_accum_sequencer
  import window_accum_sequencer_pkg::*;
#(
  parameter int unsigned X_W     = WAS_X_W,
  parameter int unsigned SCALE   = WAS_SCALE,
  parameter int unsigned MAX_LEN = WAS_MAX_LEN,
  parameter int unsigned LEN_W   = WAS_LEN_W,
  parameter int unsigned SUM_W   = WAS_SUM_W
) (
  input logic                     clk,
  input logic                     acc_rst2,
  window_accum_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ACC  = ACC;
  localparam logic [1:0] S_HOLD = HOLD;

  if (SUM_W < sum_width_needed(MAX_LEN, X_W, SCALE)) begin : g_bad_sum_w
    $error("SUM_W too small for MAX_LEN full-scale samples");
  end
  if (MAX_LEN >= 2**LEN_W) begin : g_bad_len_w
    $error("LEN_W cannot represent MAX_LEN");
  end

  logic [1:0]       state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, out_sum_q, out_sum_d, prod_s;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, out_count_q, out_count_d;
  logic [LEN_W-1:0] eff_len_s, cnt_inc_s;
  logic             out_valid_q, out_valid_d, busy_q, busy_d;
  logic             in_ready_s, in_fire_s, out_fire_s;

  window_accum_sequencer_scale_mult #(
    .X_W  (X_W),
    .SCALE(SCALE),
    .SUM_W(SUM_W)
  ) u_scale_mult (
    .in_x(bus.in_x),
    .prod(prod_s)
  );

  // Ready is dropped during reset as well as while a result is held.
  assign in_ready_s = ~acc_rst2 & (state_q != S_HOLD);
  assign in_fire_s  = bus.in_valid & in_ready_s;
  assign out_fire_s = out_valid_q & bus.out_ready;
  assign cnt_inc_s  = cnt_q + LEN_W'(1'b1);

  // Clamp zero or oversize requested lengths to the maximum window.
  always_comb begin
    if ((bus.win_len == {LEN_W{1'b0}}) || (bus.win_len > LEN_W'(MAX_LEN))) begin
      eff_len_s = LEN_W'(MAX_LEN);
    end else begin
      eff_len_s = bus.win_len;
    end
  end

  // Window sequencing: start, accumulate, early flush, hold until consumed.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire_s) begin
          len_d = eff_len_s;
          sum_d = prod_s;
          cnt_d = LEN_W'(1'b1);
          if ((eff_len_s == LEN_W'(1'b1)) || bus.flush) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (in_fire_s) begin
          sum_d = sum_q + prod_s;
          cnt_d = cnt_inc_s;
          if ((cnt_inc_s == len_q) || bus.flush) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_ACC;
          end
        end else if (bus.flush) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_ACC;
        end
      end
      S_HOLD: begin
        if (out_fire_s) begin
          sum_d   = {SUM_W{1'b0}};
          cnt_d   = {LEN_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        sum_d   = {SUM_W{1'b0}};
        cnt_d   = {LEN_W{1'b0}};
        len_d   = {LEN_W{1'b0}};
      end
    endcase
  end

  // Result and status registers follow the next state so they align with it.
  always_comb begin
    out_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d == S_ACC) || (state_d == S_HOLD);
    if (out_valid_d) begin
      out_sum_d   = sum_d;
      out_count_d = cnt_d;
    end else begin
      out_sum_d   = {SUM_W{1'b0}};
      out_count_d = {LEN_W{1'b0}};
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge acc_rst2) begin
    if (acc_rst2) begin
      state_q     <= S_IDLE;
      sum_q       <= {SUM_W{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      len_q       <= {LEN_W{1'b0}};
      out_valid_q <= 1'b0;
      out_sum_q   <= {SUM_W{1'b0}};
      out_count_q <= {LEN_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_window_accum_sequencer.sv
// Self-checking bench for window_accum_sequencer: directed vector table,
// hand-written stall/reset sequences and randomized windows.
module tb_window_accum_sequencer;
  import window_accum_sequencer_pkg::*;

  localparam int SCALE_M = 25;
  localparam int MAXL_M  = 16;

  logic clk = 1'b0;
  logic acc_rst2;

  window_accum_sequencer_if bus ();

  window_accum_sequencer dut (
    .clk     (clk),
    .acc_rst2(acc_rst2),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int wl;
    int fmode;   // 0: none, 1: flush after last sample, 2: flush with last
    int start;
    int n;
    int exp_sum;
    int exp_cnt;
  } vec_t;

  vec_t tbl [$];
  int   pool [$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: sum of x*SCALE over the samples actually in the window.
  function automatic int model_sum(input int xs[$]);
    int s = 0;
    foreach (xs[i]) s += xs[i] * SCALE_M;
    return s;
  endfunction

  function automatic int eff_len(input int wl);
    return (wl == 0 || wl > MAXL_M) ? MAXL_M : wl;
  endfunction

  task automatic add_vec(input int wl, input int fmode, input int es, input int ec,
                         input int xs[$]);
    vec_t v;
    v.wl = wl; v.fmode = fmode; v.start = pool.size(); v.n = xs.size();
    v.exp_sum = es; v.exp_cnt = ec;
    foreach (xs[i]) pool.push_back(xs[i]);
    tbl.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic put_sample(input int x, input int wl, input bit fl);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) timeout_fail("in_ready_wait");
    bus.in_valid = 1'b1;
    bus.in_x     = 4'(x);
    bus.win_len  = 5'(wl);
    bus.flush    = fl;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic run_window(input string tag, input int wl, input int xs[$],
                            input int fmode, input int es, input int ec,
                            input int stall);
    for (int i = 0; i < xs.size(); i++) begin
      put_sample(xs[i], wl, (fmode == 2) && (i == xs.size() - 1));
    end
    if (fmode == 1) begin
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_sum"}, bus.out_sum, es);
    check({tag, "_count"}, bus.out_count, ec);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_in_ready_hold"}, bus.in_ready, 0);
    for (int d = 0; d < stall; d++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 4'($urandom_range(0, 15));
      bus.flush    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, "_stall_sum"}, bus.out_sum, es);
      check({tag, "_stall_count"}, bus.out_count, ec);
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, bus.out_valid, 0);
    check({tag, "_post_sum"}, bus.out_sum, 0);
    check({tag, "_post_count"}, bus.out_count, 0);
    check({tag, "_post_busy"}, bus.busy, 0);
    check({tag, "_post_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[$];
    int wl, fmode, k, e;

    acc_rst2      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = 4'd0;
    bus.win_len   = 5'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Directed vector table.
    add_vec(4, 0, 700, 4, '{10, 5, 12, 1});
    add_vec(4, 0, 775, 4, '{13, 7, 9, 2});
    xs = {};
    for (int i = 0; i < 16; i++) xs.push_back(15);
    add_vec(0, 0, 6000, 16, xs);
    add_vec(8, 1, 175, 2, '{3, 4});
    add_vec(8, 2, 225, 3, '{3, 4, 2});
    add_vec(1, 0, 225, 1, '{9});
    xs = {};
    for (int i = 0; i < 16; i++) xs.push_back(1);
    add_vec(20, 0, 400, 16, xs);
    add_vec(5, 2, 175, 1, '{7});

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_busy", bus.busy, 0);
    acc_rst2 = 1'b0;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    @(negedge clk);

    foreach (tbl[v]) begin
      xs = {};
      for (int i = 0; i < tbl[v].n; i++) xs.push_back(pool[tbl[v].start + i]);
      run_window($sformatf("vec%0d", v), tbl[v].wl, xs, tbl[v].fmode,
                 tbl[v].exp_sum, tbl[v].exp_cnt, 0);
    end

    // HOLD stall: output stable, no sample consumed while held.
    put_sample(1, 2, 1'b0);
    put_sample(2, 2, 1'b0);
    for (int d = 0; d < 5; d++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 4'd9;
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1);
      check("stall_sum", bus.out_sum, 75);
      check("stall_count", bus.out_count, 2);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("stall_release_valid", bus.out_valid, 0);
    run_window("after_stall", 3, '{1, 1, 1}, 0, 75, 3, 0);

    // Reset mid-window discards the partial result.
    put_sample(5, 4, 1'b0);
    put_sample(6, 4, 1'b0);
    check("midrst_busy_before", bus.busy, 1);
    acc_rst2 = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    acc_rst2 = 1'b0;
    run_window("after_rst", 4, '{1, 1, 1, 1}, 0, 100, 4, 0);

    // Reset while a result is held clears it at once.
    put_sample(3, 1, 1'b0);
    check("holdrst_valid_before", bus.out_valid, 1);
    acc_rst2 = 1'b1;
    #1;
    check("holdrst_valid", bus.out_valid, 0);
    check("holdrst_sum", bus.out_sum, 0);
    @(negedge clk);
    acc_rst2 = 1'b0;
    run_window("after_holdrst", 2, '{15, 15}, 0, 750, 2, 0);

    // Randomized windows against the reference model.
    for (int r = 0; r < 30; r++) begin
      wl    = $urandom_range(0, 31);
      e     = eff_len(wl);
      fmode = $urandom_range(0, 2);
      if (fmode == 1 && e < 2) fmode = 0;
      if (fmode == 0) k = e;
      else if (fmode == 1) k = $urandom_range(1, e - 1);
      else k = $urandom_range(1, e);
      xs = {};
      for (int i = 0; i < k; i++) xs.push_back($urandom_range(0, 15));
      run_window($sformatf("rnd%0d", r), wl, xs, fmode, model_sum(xs), k,
                 $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/window_accum_sequencer.md
Name: window_accum_sequencer

Overview:
- Sequences the scaled-sample accumulate datapath, x*SCALE summed over a window of N samples.
- Replaces the free-running ripple-counter enable/clear scheme with an explicit FSM, a per-window programmable length and valid/ready handshakes on input and output.
- Sits between the sample source and the result consumer, and owns the accumulator register.
- Presents each window result, holds it until it is consumed, then starts the next window cleanly.

Parameters:
- X_W, 4: input sample width.
- SCALE, 25: constant multiplier applied to every sample.
- MAX_LEN, 16: maximum window length in samples.
- LEN_W, 5: width of win_len and out_count; must hold MAX_LEN.
- SUM_W, 13: accumulator width; must satisfy 2^SUM_W > MAX_LEN*(2^X_W-1)*SCALE. An elaboration-time check fails the build otherwise.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- acc_rst2, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: sample offered.
- in_ready, output, 1: block can accept a sample.
- in_x, input, X_W: sample value, unsigned.
- win_len, input, LEN_W: requested window length; sampled only when a window starts.
- flush, input, 1: terminate the current window early.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_sum, output, SUM_W: sum of x*SCALE over the window.
- out_count, output, LEN_W: number of samples in the result.
- busy, output, 1: window in progress (state ACC or HOLD).

Behaviour:
- Reset values (acc_rst2 high, effective immediately):
  - state=IDLE; sum=0; cnt=0; len_q=0.
  - out_valid=0, out_sum=0, out_count=0, busy=0.
  - in_ready forced to 0 while acc_rst2 is high.
- Handshake: a transfer occurs only when valid and ready are both high at a rising edge. Data is ignored otherwise.
- Effective length: win_len is used as-is for 1..MAX_LEN. win_len=0 or win_len>MAX_LEN is clamped to MAX_LEN.
- Product: prod = in_x*SCALE, unsigned, zero-extended to SUM_W. Additions never wrap under the SUM_W rule.
- FSM states: IDLE, ACC, HOLD. in_ready=1 in IDLE and ACC, 0 in HOLD.
- IDLE:
  - On input transfer: len_q<=effective length; sum<=prod; cnt<=1.
  - Next state is HOLD if len_q==1 or flush is high, else ACC.
  - flush without a transfer is ignored.
- ACC:
  - On input transfer: sum<=sum+prod; cnt<=cnt+1.
  - Go to HOLD when cnt+1==len_q or flush is high.
  - flush without a transfer goes to HOLD with the current sum and cnt (cnt>=1 is guaranteed).
  - flush and a transfer in the same cycle: the sample is included, then HOLD.
- HOLD:
  - out_valid=1; out_sum=sum; out_count=cnt. Both remain stable until the output transfer.
  - flush and in_valid are ignored.
  - On output transfer: sum<=0, cnt<=0, state<=IDLE.
  - in_ready returns to 1 the cycle after the transfer; there is one bubble cycle between windows.
- Latency: out_valid rises on the edge that accepts the last sample (or the flush edge) and is visible the following cycle.
- out_sum and out_count are registered. Outside HOLD they read as 0.
- Reset mid-operation: the partial window is discarded, no result is produced, and the first transfer after release starts a fresh window.

Decomposition:
- Shared package holds:
  - X_W, SCALE, MAX_LEN, LEN_W, SUM_W defaults;
  - the state enum {IDLE, ACC, HOLD};
  - the SUM_W sizing function used by the elaboration check.
- One natural sub-module: scale_mult. It is combinational (in_x -> in_x*SCALE, SUM_W wide) and is realised as a 2^X_W-entry constant table. It is reusable by other scaled-sample blocks.

Test Plan:
- win_len=4, samples 10,5,12,1 back-to-back -> out_sum=700, out_count=4; out_valid one cycle after the 4th transfer.
- Second window, win_len=4, samples 13,7,9,2 after the output transfer -> out_sum=775; in_ready=0 for exactly the HOLD cycles plus none after.
- win_len=0, 16 samples of 15 -> clamped to 16: out_sum=6000, out_count=16 (0x10); no wrap.
- win_len=8, samples 3,4, then flush with no transfer -> out_sum=175, out_count=2. Repeat with flush together with a third sample 2 -> out_sum=225, out_count=3.
- HOLD with out_ready low for 5 cycles while in_valid=1, in_x=9 -> out_sum and out_count stable, in_ready=0, no sample consumed; out_ready high -> IDLE, and the next window starts from 0.
- acc_rst2 pulsed after 2 accepted samples of win_len=4 -> out_valid=0 and busy=0 immediately; next window 1,1,1,1 -> out_sum=100, out_count=4.
